// File: rtl/dma_copy.sv
// dma_copy: word-copy DMA engine for the picorv32 native memory bus.
//
// The CPU programs SRC, DST and LEN through a slave register port, then sets
// START in CTRL. The engine copies LEN 32-bit words from SRC to DST, one
// read followed by one write per word, with a one-cycle idle gap after every
// bus handshake. Completion sets a sticky DONE flag that raises irq when IE=1.
//
// Register map (byte offset, addr[3:2] decoded):
//   0x0 SRC   source address, bits 1:0 forced to zero
//   0x4 DST   destination address, bits 1:0 forced to zero
//   0x8 LEN   word count (LEN_WIDTH bits, zero-extended on read)
//   0xC CTRL  write: bit0 start, bit1 clear done, bit2 ie
//             read : {29'b0, ie, done, busy}
//
// Ports:
//   clk, reset_n          system clock, asynchronous active-low reset
//   dma_sel, addr, wstrb  slave select, register offset, byte enables (0=read)
//   data_i, data_o        slave write data / registered read data
//   dma_ready             one-cycle slave acknowledge per dma_sel assertion
//   m_valid, m_addr       master request and word-aligned address
//   m_wstrb, m_wdata      4'h0 for reads, 4'hf with data for writes
//   m_rdata, m_ready      master read data and target acknowledge
//   irq                   level interrupt, done & ie
module dma_copy #(
  parameter int LEN_WIDTH = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        dma_sel,
  input  logic [3:0]  addr,
  input  logic [3:0]  wstrb,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        dma_ready,
  output logic        m_valid,
  output logic [31:0] m_addr,
  output logic [3:0]  m_wstrb,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_ready,
  output logic        irq
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_RGAP,
    S_WRITE,
    S_WGAP
  } state_t;

  state_t                 state_q, state_d;
  logic [31:0]            src_q, src_d;
  logic [31:0]            dst_q, dst_d;
  logic [LEN_WIDTH-1:0]   len_q, len_d;
  logic                   ie_q, ie_d;
  logic                   done_q, done_d;
  logic [31:0]            cur_src_q, cur_src_d;
  logic [31:0]            cur_dst_q, cur_dst_d;
  logic [LEN_WIDTH-1:0]   cur_len_q, cur_len_d;
  logic [31:0]            buf_q, buf_d;
  logic                   sel_seen_q, sel_seen_d;
  logic                   rdy_q, rdy_d;
  logic [31:0]            rdata_q, rdata_d;
  logic                   m_valid_q, m_valid_d;
  logic [31:0]            m_addr_q, m_addr_d;
  logic [3:0]             m_wstrb_q, m_wstrb_d;
  logic [31:0]            m_wdata_q, m_wdata_d;

  logic                   busy;
  logic                   sel_fire;
  logic                   wr_en;
  logic                   start_req;
  logic [31:0]            len_ext;
  logic [31:0]            len_merged;
  logic [31:0]            rd_mux;
  logic                   unused_bits;

  // Byte-lane merge of a register write.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  be);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) begin
      r[8*b +: 8] = be[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    end
    return r;
  endfunction

  assign busy = (state_q != S_IDLE);

  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    dst_d      = dst_q;
    len_d      = len_q;
    ie_d       = ie_q;
    done_d     = done_q;
    cur_src_d  = cur_src_q;
    cur_dst_d  = cur_dst_q;
    cur_len_d  = cur_len_q;
    buf_d      = buf_q;
    m_valid_d  = m_valid_q;
    m_addr_d   = m_addr_q;
    m_wstrb_d  = m_wstrb_q;
    m_wdata_d  = m_wdata_q;
    start_req  = 1'b0;
    rd_mux     = '0;

    // A slave access is acknowledged once per dma_sel assertion: the first
    // cycle dma_sel is seen fires, and sel_seen blocks re-firing until it drops.
    sel_fire   = dma_sel & ~sel_seen_q;
    wr_en      = sel_fire & (wstrb != 4'h0);
    sel_seen_d = dma_sel;
    rdy_d      = sel_fire;

    len_ext    = 32'(len_q);
    len_merged = merge_bytes(len_ext, data_i, wstrb);

    case (addr[3:2])
      2'd0:    rd_mux = src_q;
      2'd1:    rd_mux = dst_q;
      2'd2:    rd_mux = len_ext;
      default: rd_mux = {29'b0, ie_q, done_q, busy};
    endcase
    rdata_d = sel_fire ? rd_mux : '0;

    if (wr_en) begin
      case (addr[3:2])
        2'd0: if (!busy) src_d = merge_bytes(src_q, data_i, wstrb) & 32'hFFFF_FFFC;
        2'd1: if (!busy) dst_d = merge_bytes(dst_q, data_i, wstrb) & 32'hFFFF_FFFC;
        2'd2: if (!busy) len_d = len_merged[LEN_WIDTH-1:0];
        default: begin
          if (wstrb[0]) begin
            ie_d = data_i[2];
            if (data_i[1]) done_d = 1'b0;
            start_req = data_i[0];
          end
        end
      endcase
    end

    // The FSM is evaluated after the register writes so that a start or a
    // completion overrides a done-clear arriving in the same cycle.
    case (state_q)
      S_IDLE: begin
        if (start_req) begin
          if (len_q != '0) begin
            done_d    = 1'b0;
            cur_src_d = src_q;
            cur_dst_d = dst_q;
            cur_len_d = len_q;
            m_valid_d = 1'b1;
            m_addr_d  = src_q;
            m_wstrb_d = 4'h0;
            state_d   = S_READ;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_READ: begin
        if (m_ready) begin
          buf_d     = m_rdata;
          m_valid_d = 1'b0;
          state_d   = S_RGAP;
        end
      end
      S_RGAP: begin
        m_valid_d = 1'b1;
        m_addr_d  = cur_dst_q;
        m_wstrb_d = 4'hf;
        m_wdata_d = buf_q;
        state_d   = S_WRITE;
      end
      S_WRITE: begin
        if (m_ready) begin
          cur_src_d = cur_src_q + 32'd4;
          cur_dst_d = cur_dst_q + 32'd4;
          cur_len_d = cur_len_q - LEN_WIDTH'(1);
          m_valid_d = 1'b0;
          state_d   = S_WGAP;
        end
      end
      S_WGAP: begin
        if (cur_len_q == '0) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          m_valid_d = 1'b1;
          m_addr_d  = cur_src_q;
          m_wstrb_d = 4'h0;
          state_d   = S_READ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      src_q      <= '0;
      dst_q      <= '0;
      len_q      <= '0;
      ie_q       <= 1'b0;
      done_q     <= 1'b0;
      cur_src_q  <= '0;
      cur_dst_q  <= '0;
      cur_len_q  <= '0;
      buf_q      <= '0;
      sel_seen_q <= 1'b0;
      rdy_q      <= 1'b0;
      rdata_q    <= '0;
      m_valid_q  <= 1'b0;
      m_addr_q   <= '0;
      m_wstrb_q  <= '0;
      m_wdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      len_q      <= len_d;
      ie_q       <= ie_d;
      done_q     <= done_d;
      cur_src_q  <= cur_src_d;
      cur_dst_q  <= cur_dst_d;
      cur_len_q  <= cur_len_d;
      buf_q      <= buf_d;
      sel_seen_q <= sel_seen_d;
      rdy_q      <= rdy_d;
      rdata_q    <= rdata_d;
      m_valid_q  <= m_valid_d;
      m_addr_q   <= m_addr_d;
      m_wstrb_q  <= m_wstrb_d;
      m_wdata_q  <= m_wdata_d;
    end
  end

  assign data_o    = rdata_q;
  assign dma_ready = rdy_q;
  assign m_valid   = m_valid_q;
  assign m_addr    = m_addr_q;
  assign m_wstrb   = m_wstrb_q;
  assign m_wdata   = m_wdata_q;
  assign irq       = done_q & ie_q;

  // Byte-offset bits below the word and LEN bits above LEN_WIDTH are don't-care.
  assign unused_bits = ^{addr[1:0], len_merged};

endmodule

// File: doc/dma_copy.md
# dma_copy

Word-copy DMA engine for the picorv32 SoC. It occupies the initiator side of the native memory bus (valid/ready handshake, `wstrb`, `addr`, `wdata`, `rdata`), the same bus the CPU drives. It also exposes a slave register port in the style of the other peripherals, so the CPU can program a source, a destination and a word count. Top-level bus arbitration between the CPU and this engine is outside this block: the master port simply holds its request until `m_ready`.

## Interface
- `LEN_WIDTH`, default 16: width of the word-count register; maximum transfer is 2^LEN_WIDTH−1 words.
- `clk` input 1: single system clock.
- `reset_n` input 1: asynchronous, active-low reset.
- `dma_sel` input 1: slave select, asserted while the CPU addresses this block.
- `addr` input 4: slave register offset (byte address bits 3:0).
- `wstrb` input 4: slave write byte enables; 0 means read.
- `data_i` input 32: slave write data.
- `data_o` output 32: slave read data.
- `dma_ready` output 1: slave handshake complete.
- `m_valid` output 1: master request.
- `m_addr` output 32: master address, always word-aligned.
- `m_wstrb` output 4: 4'h0 on reads, 4'hf on writes.
- `m_wdata` output 32: master write data.
- `m_rdata` input 32: master read data.
- `m_ready` input 1: target done.
- `irq` output 1: level interrupt, equal to `done & ie`.

## Operation
- **Registers.**
  - 0x0 SRC, 0x4 DST: 32-bit. Bits 1:0 are forced to 0 on write.
  - 0x8 LEN: word count, zero-extended on read.
  - 0xC CTRL/STATUS:
    - Write bit0=1 → start.
    - Write bit1=1 → clear `done`.
    - Bit2 is `ie` (read/write).
    - Read returns {29'b0, ie, done, busy}.
- **Write masking.** Register writes honour `wstrb` per byte. CTRL start/clear act only when byte lane 0 is enabled.
- **Writes while busy.**
  - Writes to SRC/DST/LEN are ignored.
  - A start is ignored.
  - The `ie` write and the done-clear still apply.
- **Working copies.** Start copies SRC/DST/LEN into working counters `cur_src`/`cur_dst`/`cur_len`. The programmed registers are not modified, so reading them back returns the programmed values.
- **FSM states:** IDLE, READ, RGAP, WRITE, WGAP.
  - IDLE: on start with LEN≠0, set `busy`, clear `done`, go to READ. Start with LEN=0 sets `done` directly, `busy` stays 0, and the FSM stays in IDLE.
  - READ: `m_valid`=1, `m_addr`=`cur_src`, `m_wstrb`=0. On `m_ready`, capture `m_rdata` into `buf` and go to RGAP.
  - RGAP: `m_valid`=0 for one cycle, then go to WRITE.
  - WRITE: `m_valid`=1, `m_addr`=`cur_dst`, `m_wstrb`=4'hf, `m_wdata`=`buf`. On `m_ready`:
    - `cur_src` += 4 and `cur_dst` += 4, modulo 2^32 (wrap from 0xFFFFFFFC to 0).
    - `cur_len` −= 1.
    - Go to WGAP.
  - WGAP: `m_valid`=0 for one cycle. If `cur_len`=0: clear `busy`, set `done`, go to IDLE; otherwise go to READ.
- **Sticky done.** `done` stays set until it is cleared by CTRL bit1 or a new start. A start and a clear in the same write: start wins.
- **Reset.** Asynchronous reset in any state returns the FSM to IDLE immediately. All registers and outputs go to 0, including mid-transfer.

## Timing
- **Reset values:** `m_valid`=0, `m_addr`=0, `m_wstrb`=0, `m_wdata`=0, `data_o`=0, `dma_ready`=0, `irq`=0.
- **Slave port.**
  - `dma_ready` is registered: high one cycle after `dma_sel` is first seen, for exactly one cycle.
  - `data_o` is valid in the same cycle as `dma_ready`.
  - `dma_ready` does not re-assert until `dma_sel` has dropped.
  - The register write takes effect on the edge that raises `dma_ready`.
- **Master port.**
  - `m_valid`, `m_addr`, `m_wstrb` and `m_wdata` are registered and held stable until the edge on which `m_ready`=1 is sampled.
  - `m_valid` deasserts on that same edge.
  - `m_ready` is ignored while `m_valid`=0.
- **Latency.**
  - First READ request is one cycle after the start-write edge.
  - With targets that assert ready one cycle after valid, each word takes 6 cycles: READ 2, RGAP 1, WRITE 2, WGAP 1.
  - `done`/`irq` rise on the edge that leaves the final WGAP.

## Test plan
- Reset values: assert `reset_n`=0 → every output is 0. Read 0xC → 0.
- Basic copy:
  - Program SRC=0x100, DST=0x200, LEN=4, `ie`=1, and start; target returns 0xA0..0xA3 after 1 cycle.
  - Expect reads at 0x100, 0x104, 0x108, 0x10C.
  - Expect writes at 0x200..0x20C of 0xA0..0xA3 with `m_wstrb`=f.
  - Expect `irq`=1 exactly 24 cycles after the first `m_valid`. STATUS reads 0x6.
- Stalling target: `m_ready` delayed 5 cycles → `m_addr`/`m_wdata` stay stable throughout, and no duplicate or skipped transfer occurs.
- Edge programming:
  - LEN=0 start → `done`=1 the next cycle with no `m_valid`.
  - SRC=0xFFFFFFFC, LEN=2 → second read at 0x00000000.
  - SRC write of 0x103 reads back as 0x100.
- Busy protection: during a LEN=3 copy, write DST=0x999 and start → both ignored and the copy completes unchanged. Clear `done` via bit1 → `irq` drops the next cycle.
- Mid-transfer reset: pulse `reset_n` low while in WRITE → `m_valid` drops asynchronously and STATUS reads 0 after release.
